// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: turns key edges into note-on/off events.
// Optional VOICE_STEAL_EN: a press with every voice busy steals the oldest voice.
module voice_alloc #(
  parameter int NVOICES = 4,
  parameter int NKEYS   = 13,
  parameter int VW      = 2
) (
  input  logic                 clk,
  input  logic                 ar,
  input  logic [NKEYS-1:0]     bitmask,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic                 evt_on,
  output logic [VW-1:0]        evt_voice,
  output logic [3:0]           evt_key,
  output logic                 evt_steal,
  output logic [NVOICES-1:0]   voice_active,
  output logic [4*NVOICES-1:0] voice_key
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t             state, state_n;
  logic [NKEYS-1:0]   s1, smask, prev, prev_n;
  logic [3:0]         key_idx, key_idx_n;
  logic [NVOICES-1:0] act, act_n;
  logic [3:0]         vkey   [NVOICES];
  logic [3:0]         vkey_n [NVOICES];
  logic [7:0]         age    [NVOICES];
  logic [7:0]         age_n  [NVOICES];
  logic               ev_valid_n, ev_on_n, ev_steal_n;
  logic [VW-1:0]      ev_voice_n;
  logic [3:0]         ev_key_n;

  logic               cur, was, last;
  logic               free_ok, hit, do_alloc;
  logic [VW-1:0]      free_idx, hit_idx, sel;

  assign cur  = smask[key_idx];
  assign was  = prev[key_idx];
  assign last = (key_idx == 4'(NKEYS-1));

  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    for (int v = NVOICES-1; v >= 0; v--) begin
      if (!act[v]) begin
        free_ok  = 1'b1;
        free_idx = VW'(v);
      end
      if (act[v] && vkey[v] == key_idx) begin
        hit     = 1'b1;
        hit_idx = VW'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [VW-1:0] old_idx;
  logic [7:0]    old_age;
  logic          ev_steal_q;

  // strict compare keeps ties on the lowest index
  always_comb begin
    old_idx = '0;
    old_age = age[0];
    for (int v = 1; v < NVOICES; v++) begin
      if (age[v] > old_age) begin
        old_age = age[v];
        old_idx = VW'(v);
      end
    end
  end
`endif

  always_comb begin
    state_n    = state;
    key_idx_n  = key_idx;
    prev_n     = prev;
    act_n      = act;
    vkey_n     = vkey;
    age_n      = age;
    ev_valid_n = evt_valid;
    ev_on_n    = evt_on;
    ev_voice_n = evt_voice;
    ev_key_n   = evt_key;
    ev_steal_n = evt_steal;
    do_alloc   = 1'b0;
    sel        = free_idx;
    unique case (state)
      IDLE: begin
        if (smask != prev) begin
          state_n   = SCAN;
          key_idx_n = '0;
        end
      end
      SCAN: begin
        prev_n[key_idx] = cur;
        if (cur && !was) begin
          if (free_ok) begin
            do_alloc   = 1'b1;
            ev_steal_n = 1'b0;
          end
`ifdef VOICE_STEAL_EN
          else begin
            do_alloc   = 1'b1;
            sel        = old_idx;
            ev_steal_n = 1'b1;
          end
`endif
        end else if (!cur && was && hit) begin
          act_n[hit_idx] = 1'b0;
          ev_valid_n     = 1'b1;
          ev_on_n        = 1'b0;
          ev_voice_n     = hit_idx;
          ev_key_n       = key_idx;
          ev_steal_n     = 1'b0;
        end
        if (do_alloc) begin
          for (int v = 0; v < NVOICES; v++) begin
            if (VW'(v) == sel) begin
              act_n[v]  = 1'b1;
              vkey_n[v] = key_idx;
              age_n[v]  = 8'd0;
            end else if (act[v] && age[v] != 8'hff) begin
              age_n[v] = age[v] + 8'd1;
            end
          end
          ev_valid_n = 1'b1;
          ev_on_n    = 1'b1;
          ev_voice_n = sel;
          ev_key_n   = key_idx;
        end
        if (ev_valid_n)
          state_n = EMIT;
        else if (last)
          state_n = IDLE;
        else
          key_idx_n = key_idx + 4'd1;
      end
      EMIT: begin
        if (evt_ready) begin
          ev_valid_n = 1'b0;
          if (last) begin
            state_n = IDLE;
          end else begin
            state_n   = SCAN;
            key_idx_n = key_idx + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ar) begin
      s1        <= '0;
      smask     <= '0;
      state     <= IDLE;
      key_idx   <= '0;
      prev      <= '0;
      act       <= '0;
      evt_valid <= 1'b0;
      evt_on    <= 1'b0;
      evt_voice <= '0;
      evt_key   <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        vkey[v] <= '0;
        age[v]  <= '0;
      end
    end else begin
      s1        <= bitmask;
      smask     <= s1;
      state     <= state_n;
      key_idx   <= key_idx_n;
      prev      <= prev_n;
      act       <= act_n;
      evt_valid <= ev_valid_n;
      evt_on    <= ev_on_n;
      evt_voice <= ev_voice_n;
      evt_key   <= ev_key_n;
      vkey      <= vkey_n;
      age       <= age_n;
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk) begin
    if (ar) ev_steal_q <= 1'b0;
    else    ev_steal_q <= ev_steal_n;
  end
  assign evt_steal = ev_steal_q;
`else
  logic unused_steal;
  assign unused_steal = ev_steal_n;
  assign evt_steal    = 1'b0;
`endif

  assign voice_active = act;

  for (genvar v = 0; v < NVOICES; v++) begin : g_vk
    assign voice_key[4*v +: 4] = vkey[v];
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc (default 4 voices, 13 keys).
// Expectations follow VOICE_STEAL_EN when it is defined for the build.
module tb_voice_alloc;

  logic        clk = 1'b0;
  logic        ar;
  logic [12:0] bitmask;
  logic        evt_valid, evt_ready, evt_on, evt_steal;
  logic [1:0]  evt_voice;
  logic [3:0]  evt_key;
  logic [3:0]  voice_active;
  logic [15:0] voice_key;

  int checks = 0;
  int errors = 0;

  voice_alloc dut (
    .clk(clk), .ar(ar), .bitmask(bitmask),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_on(evt_on), .evt_voice(evt_voice), .evt_key(evt_key),
    .evt_steal(evt_steal), .voice_active(voice_active),
    .voice_key(voice_key)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_evt(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (evt_valid) break;
      tick();
    end
    check({tag, "_timeout"}, 32'(evt_valid), 32'd1);
  endtask

  function automatic logic [31:0] ev(input logic on, input logic [1:0] v,
                                     input logic [3:0] k, input logic st);
    return 32'({1'b1, on, v, k, st});
  endfunction

  function automatic logic [31:0] cur_ev();
    return 32'({evt_valid, evt_on, evt_voice, evt_key, evt_steal});
  endfunction

  initial begin
    int  bad;
    bit  seen;
    ar        = 1'b1;
    bitmask   = '0;
    evt_ready = 1'b1;
    tick(2);
    ar = 1'b0;
    check("rst_evt", cur_ev(), 32'd0);
    check("rst_act", 32'(voice_active), 32'd0);
    check("rst_vkey", 32'(voice_key), 32'd0);

    // single press latency: edge 4
    bitmask = 13'h001;
    bad = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (evt_valid) bad++;
    end
    check("lat_early", 32'(bad), 32'd0);
    tick();
    check("lat_evt", cur_ev(), ev(1'b1, 2'd0, 4'd0, 1'b0));
    check("lat_act", 32'(voice_active), 32'h1);
    check("lat_vkey", 32'(voice_key[3:0]), 32'd0);
    tick();
    check("lat_drop", 32'(evt_valid), 32'd0);
    tick(20);

    bitmask = '0;
    wait_evt("rel0", 40);
    check("rel0_evt", cur_ev(), ev(1'b0, 2'd0, 4'd0, 1'b0));
    check("rel0_act", 32'(voice_active), 32'h0);
    tick(20);

    // backpressure on two simultaneous presses
    evt_ready = 1'b0;
    bitmask   = 13'h024;
    wait_evt("k2", 40);
    check("k2_evt", cur_ev(), ev(1'b1, 2'd0, 4'd2, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("k2_hold", cur_ev(), ev(1'b1, 2'd0, 4'd2, 1'b0));
    end
    evt_ready = 1'b1;
    tick();
    check("k2_acc", 32'(evt_valid), 32'd0);
    wait_evt("k5", 10);
    check("k5_evt", cur_ev(), ev(1'b1, 2'd1, 4'd5, 1'b0));
    check("k5_act", 32'(voice_active), 32'h3);
    check("k5_vkey", 32'(voice_key), 32'h0052);
    tick();

    bitmask = '0;
    wait_evt("off2", 40);
    check("off2_evt", cur_ev(), ev(1'b0, 2'd0, 4'd2, 1'b0));
    tick();
    wait_evt("off5", 20);
    check("off5_evt", cur_ev(), ev(1'b0, 2'd1, 4'd5, 1'b0));
    check("off5_act", 32'(voice_active), 32'h0);
    tick(20);

    // press and release key 3
    bitmask = 13'h008;
    wait_evt("on3", 40);
    check("on3_evt", cur_ev(), ev(1'b1, 2'd0, 4'd3, 1'b0));
    tick(20);
    bitmask = '0;
    wait_evt("off3", 40);
    check("off3_evt", cur_ev(), ev(1'b0, 2'd0, 4'd3, 1'b0));
    check("off3_act", 32'(voice_active), 32'h0);
    tick(20);

    // fill all voices, then a fifth press
    for (int i = 0; i < 4; i++) begin
      bitmask[i] = 1'b1;
      wait_evt("fill", 40);
      check("fill_evt", cur_ev(), ev(1'b1, 2'(i), 4'(i), 1'b0));
      tick(20);
    end
    check("fill_vkey", 32'(voice_key), 32'h3210);
    check("fill_act", 32'(voice_active), 32'hf);
    bitmask[4] = 1'b1;
`ifdef VOICE_STEAL_EN
    wait_evt("steal", 40);
    check("steal_evt", cur_ev(), ev(1'b1, 2'd0, 4'd4, 1'b1));
    check("steal_vkey", 32'(voice_key), 32'h3214);
    tick(20);
    // released key 0 no longer owns a voice
    bitmask[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (evt_valid) seen = 1'b1;
    end
    check("stolen_rel", 32'(seen), 32'd0);
`else
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (evt_valid) seen = 1'b1;
    end
    check("drop_evt", 32'(seen), 32'd0);
    check("drop_vkey", 32'(voice_key), 32'h3210);
    check("drop_act", 32'(voice_active), 32'hf);
`endif
    bitmask = '0;
    tick(80);
    check("drain_act", 32'(voice_active), 32'h0);

    // reset while an event is stalled
    evt_ready = 1'b0;
    bitmask   = 13'h003;
    wait_evt("pre_rst", 40);
    check("pre_rst_evt", cur_ev(), ev(1'b1, 2'd0, 4'd0, 1'b0));
    ar = 1'b1;
    tick();
    ar = 1'b0;
    check("rst_mid_valid", 32'(evt_valid), 32'd0);
    check("rst_mid_act", 32'(voice_active), 32'h0);
    evt_ready = 1'b1;
    wait_evt("re0", 40);
    check("re0_evt", cur_ev(), ev(1'b1, 2'd0, 4'd0, 1'b0));
    tick();
    wait_evt("re1", 20);
    check("re1_evt", cur_ev(), ev(1'b1, 2'd1, 4'd1, 1'b0));
    check("re1_act", 32'(voice_active), 32'h3);
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
